// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial RAM/IO arbiter between instruction fetch and the
// load/store buffer. Words are moved one byte per cycle, little-endian.
// Optional build macro: MEM_ARB_RR_EN -- round-robin tie-break between the
// two requesters. When it is undefined the LSB always wins a tie.
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ready,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic        mem_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IFETCH = 2'd1,
    S_LOAD   = 2'd2,
    S_STORE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;       // index of the byte currently on the bus
  logic [2:0]  r_n;         // bytes in the current transfer (1, 2 or 4)
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;       // read data assembly
  logic        r_if_ready;
  logic        r_lsb_ready;

  state_t      w_state_nxt;
  logic [2:0]  w_cnt_nxt;
  logic        w_if_ready_nxt;
  logic        w_lsb_ready_nxt;
  logic        w_grant;
  logic        w_sample;
  logic        w_can_grant;
  logic        w_pick_lsb;
  logic [2:0]  w_n_grant;
  logic [31:0] w_addr;
  logic        w_stall;
  logic [1:0]  w_byte_idx;

  // Address of the current byte; the 32-bit add wraps naturally.
  assign w_addr     = r_base + {29'd0, r_cnt};
  // A store to the I/O window waits while the sink is full.
  assign w_stall    = (r_state == S_STORE) && (w_addr[17:16] == 2'b11) && io_buffer_full;
  // The byte arriving on mem_din belongs to the address of the previous cycle.
  assign w_byte_idx = r_cnt[1:0] - 2'd1;
  // No new request is taken while a done pulse is still visible.
  assign w_can_grant = !clear && !r_if_ready && !r_lsb_ready;

`ifdef MEM_ARB_RR_EN
  logic r_last_lsb;         // 1 when the most recent grant went to the LSB

  // On a tie, favour whichever side was not served last.
  always_comb begin
    w_pick_lsb = lsb_req && (!if_req || !r_last_lsb);
  end

  // Remember who won the most recent grant.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_last_lsb <= 1'b0;
    end else if (rdy_in && w_grant) begin
      r_last_lsb <= w_pick_lsb;
    end
  end
`else
  // Fixed priority: the LSB always wins a tie.
  always_comb begin
    w_pick_lsb = lsb_req;
  end
`endif

  // Byte count of the transfer about to be granted (len 3 behaves as a word).
  always_comb begin
    w_n_grant = 3'd4;
    if (w_pick_lsb) begin
      case (lsb_len)
        2'd0:    w_n_grant = 3'd1;
        2'd1:    w_n_grant = 3'd2;
        default: w_n_grant = 3'd4;
      endcase
    end
  end

  // Next-state, byte counter and done-pulse decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_if_ready_nxt  = 1'b0;
    w_lsb_ready_nxt = 1'b0;
    w_grant         = 1'b0;
    w_sample        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 3'd0;
        if (w_can_grant) begin
          if (w_pick_lsb) begin
            w_grant     = 1'b1;
            w_state_nxt = lsb_we ? S_STORE : S_LOAD;
          end else if (if_req) begin
            w_grant     = 1'b1;
            w_state_nxt = S_IFETCH;
          end
        end
      end
      S_IFETCH, S_LOAD: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_sample = (r_cnt != 3'd0);
          if (r_cnt == r_n) begin
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = 3'd0;
            w_if_ready_nxt  = (r_state == S_IFETCH);
            w_lsb_ready_nxt = (r_state == S_LOAD);
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
      S_STORE: begin
        // A started store always completes; clear is ignored here.
        if (!w_stall) begin
          if (r_cnt == r_n - 3'd1) begin
            w_state_nxt     = S_IDLE;
            w_cnt_nxt       = 3'd0;
            w_lsb_ready_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State, transfer context and read assembly; frozen while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_n         <= 3'd0;
      r_base      <= 32'd0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_if_ready  <= 1'b0;
      r_lsb_ready <= 1'b0;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_lsb_ready <= w_lsb_ready_nxt;
      if (w_grant) begin
        r_base  <= w_pick_lsb ? lsb_addr : if_addr;
        r_wdata <= lsb_wdata;
        r_n     <= w_n_grant;
        // Cleared here so short loads come out zero-extended.
        r_buf   <= 32'd0;
      end else if (w_sample) begin
        r_buf[{w_byte_idx, 3'b000} +: 8] <= mem_din;
      end
    end
  end

  // Bus outputs decode from the current state; IDLE drives everything to 0.
  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    if (r_state != S_IDLE) begin
      mem_a = w_addr;
    end
    if (r_state == S_STORE) begin
      mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
      mem_wr   = rdy_in && !w_stall;
    end
  end

  assign mem_busy  = (r_state != S_IDLE);
  assign if_ready  = r_if_ready;
  assign lsb_ready = r_lsb_ready;
  assign if_data   = r_buf;
  assign lsb_rdata = r_buf;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table-driven transfers plus hand-written
// sequences for I/O stall, clear, rdy_in freeze, arbitration and reset.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_we;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_ready;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        mem_busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_ready(lsb_ready), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .mem_busy(mem_busy)
  );

  always #5 clk_in = ~clk_in;

  // RAM contents: a fixed fetch word at 0x100, elsewhere low address byte + 0x11.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: ram_byte = 8'h13;
      32'h101: ram_byte = 8'h05;
      32'h102: ram_byte = 8'h00;
      32'h103: ram_byte = 8'h00;
      default: ram_byte = a[7:0] + 8'h11;
    endcase
  endfunction

  // RAM read port: data appears one cycle after its address.
  always @(posedge clk_in) mem_din <= ram_byte(mem_a);

  typedef struct {
    logic        is_lsb;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          n;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drop_reqs();
    if_req  = 1'b0;
    lsb_req = 1'b0;
    lsb_we  = 1'b0;
  endtask

  // Run one transfer; s counts edges after the grant edge at sample time.
  task automatic run_vec(input vec_t v, input string nm, input int clr_at);
    int last;
    logic rdy;
    if (v.is_lsb) begin
      lsb_req = 1'b1; lsb_we = v.we; lsb_len = v.len;
      lsb_addr = v.addr; lsb_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    last = v.we ? v.n : v.n + 1;
    for (int s = 0; s <= last; s++) begin
      tick();
      rdy = v.is_lsb ? lsb_ready : if_ready;
      check($sformatf("%s ready s%0d", nm, s), {31'd0, rdy}, {31'd0, s == last});
      if (s < v.n) begin
        check($sformatf("%s mem_a s%0d", nm, s), mem_a, v.addr + 32'(s));
        check($sformatf("%s mem_wr s%0d", nm, s), {31'd0, mem_wr}, {31'd0, v.we});
        if (v.we)
          check($sformatf("%s mem_dout s%0d", nm, s), {24'd0, mem_dout},
                (v.wdata >> (8 * s)) & 32'hFF);
      end
      if (s == last && !v.we)
        check($sformatf("%s data", nm), v.is_lsb ? lsb_rdata : if_data, v.exp);
      clear = (s == clr_at);
    end
    clear = 1'b0;
    drop_reqs();
    tick();
    check($sformatf("%s pulse end", nm), {30'd0, if_ready, lsb_ready}, 32'd0);
    check($sformatf("%s idle after", nm), {31'd0, mem_busy}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t v;
    int   seen;
    logic got, winner, exp_lsb;

    // {is_lsb, we, len, addr, wdata, expected read data, byte count}
    vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0, 32'h0000_0513, 4};
    vecs[1] = '{1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0, 32'h5453_5251, 4};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 32'h0000_007F, 32'h0, 32'h0000_0090, 1};
    vecs[3] = '{1'b1, 1'b0, 2'd1, 32'h0000_00FE, 32'h0, 32'h0000_100F, 2};
    vecs[4] = '{1'b1, 1'b0, 2'd3, 32'h0000_0020, 32'h0, 32'h3433_3231, 4};
    vecs[5] = '{1'b0, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0, 32'h1211_100F, 4};
    vecs[6] = '{1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 4};
    vecs[7] = '{1'b1, 1'b1, 2'd0, 32'h0000_0080, 32'hAABB_CC41, 32'h0, 1};
    vecs[8] = '{1'b1, 1'b1, 2'd1, 32'h0000_0301, 32'h0000_CAFE, 32'h0, 2};

    rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_addr = 32'd0; lsb_len = 2'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
    drop_reqs();
    tick(); tick();
    check("reset mem_a", mem_a, 32'd0);
    check("reset flags", {28'd0, mem_wr, mem_busy, if_ready, lsb_ready}, 32'd0);
    check("reset if_data", if_data, 32'd0);
    check("reset mem_dout", {24'd0, mem_dout}, 32'd0);
    rst_n_in = 1'b1;
    tick(); tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i), -1);

    // Store in flight is unaffected by clear.
    v = '{1'b1, 1'b1, 2'd2, 32'h0000_0400, 32'h1122_3344, 32'h0, 4};
    run_vec(v, "store_clear", 1);

    // I/O store held off by a full sink for three cycles.
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_len = 2'd0;
    lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_0041; io_buffer_full = 1'b1;
    for (int s = 0; s <= 3; s++) begin
      tick();
      check($sformatf("io stall wr s%0d", s), {31'd0, mem_wr}, 32'd0);
      check($sformatf("io stall a s%0d", s), mem_a, 32'h0003_0000);
      check($sformatf("io stall rdy s%0d", s), {31'd0, lsb_ready}, 32'd0);
    end
    io_buffer_full = 1'b0;
    #1;
    check("io resume wr", {31'd0, mem_wr}, 32'd1);
    check("io resume dout", {24'd0, mem_dout}, 32'h41);
    tick();
    check("io ready", {31'd0, lsb_ready}, 32'd1);
    drop_reqs();
    tick();
    check("io pulse end", {31'd0, lsb_ready}, 32'd0);

    // clear two cycles into a fetch aborts it without a done pulse.
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    check("ifclr busy s0", {31'd0, mem_busy}, 32'd1);
    tick();
    clear = 1'b1; if_req = 1'b0;
    tick();
    check("ifclr idle", {31'd0, mem_busy}, 32'd0);
    check("ifclr mem_a", mem_a, 32'd0);
    clear = 1'b0;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      if (if_ready) seen++;
      tick();
    end
    check("ifclr no ready", 32'(seen), 32'd0);

    // clear in IDLE suppresses the grant on that edge only.
    if_req = 1'b1; if_addr = 32'h0000_0100; clear = 1'b1;
    tick();
    check("idleclr no grant", {31'd0, mem_busy}, 32'd0);
    clear = 1'b0;
    tick();
    check("idleclr grant", {31'd0, mem_busy}, 32'd1);
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      tick();
      got = if_ready;
    end
    check("idleclr ready seen", {31'd0, got}, 32'd1);
    check("idleclr data", if_data, 32'h0000_0513);
    drop_reqs();
    tick();

    // rdy_in low for two edges early in a word load stretches it by two.
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_len = 2'd2; lsb_addr = 32'h0000_0040;
    tick();
    check("frz load a s0", mem_a, 32'h0000_0040);
    rdy_in = 1'b0;
    tick();
    check("frz load a held", mem_a, 32'h0000_0040);
    tick();
    check("frz load busy", {31'd0, mem_busy}, 32'd1);
    rdy_in = 1'b1;
    for (int s = 3; s <= 7; s++) begin
      tick();
      check($sformatf("frz load rdy s%0d", s), {31'd0, lsb_ready}, {31'd0, s == 7});
    end
    check("frz load data", lsb_rdata, 32'h5453_5251);
    drop_reqs();
    tick();

    // rdy_in low during a store forces mem_wr low and holds the byte.
    lsb_req = 1'b1; lsb_we = 1'b1; lsb_len = 2'd2;
    lsb_addr = 32'h0000_0500; lsb_wdata = 32'hA1B2_C3D4;
    tick();
    check("frz st wr s0", {31'd0, mem_wr}, 32'd1);
    rdy_in = 1'b0;
    tick();
    check("frz st wr forced", {31'd0, mem_wr}, 32'd0);
    check("frz st a held", mem_a, 32'h0000_0500);
    check("frz st dout held", {24'd0, mem_dout}, 32'hD4);
    rdy_in = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t < 4) check($sformatf("frz st a t%0d", t), mem_a, 32'h0000_0500 + 32'(t));
      check($sformatf("frz st rdy t%0d", t), {31'd0, lsb_ready}, {31'd0, t == 4});
    end
    drop_reqs();
    tick();

    // Both sides keep requesting; the last grant so far went to the LSB.
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h0000_007F;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    for (int r = 0; r < 4; r++) begin
      got = 1'b0; winner = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
        tick();
        if (if_ready || lsb_ready) begin
          got = 1'b1;
          winner = lsb_ready;
          check($sformatf("arb r%0d single", r), {31'd0, if_ready && lsb_ready}, 32'd0);
        end
      end
      check($sformatf("arb r%0d done", r), {31'd0, got}, 32'd1);
`ifdef MEM_ARB_RR_EN
      exp_lsb = (r % 2 == 1);
`else
      exp_lsb = 1'b1;
`endif
      check($sformatf("arb r%0d winner_lsb", r), {31'd0, winner}, {31'd0, exp_lsb});
    end
    drop_reqs();
    tick(); tick();

    // Reset between clock edges in the middle of a load.
    lsb_req = 1'b1; lsb_we = 1'b0; lsb_len = 2'd2; lsb_addr = 32'h0000_0040;
    tick(); tick();
    #2 rst_n_in = 1'b0;
    #1;
    check("rst mid busy", {31'd0, mem_busy}, 32'd0);
    check("rst mid mem_a", mem_a, 32'd0);
    check("rst mid rdata", lsb_rdata, 32'd0);
    drop_reqs();
    rst_n_in = 1'b1;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (lsb_ready || mem_busy) seen++;
    end
    check("rst mid no ready", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk_in  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-003 rdy_in  input  1  global enable; low freezes all state.
REQ-004 clear  input  1  misprediction flush from ROB.
REQ-005 if_req / if_addr  input  1/32  instruction fetch request and byte address (always 4 bytes).
REQ-006 if_ready / if_data  output  1/32  one-cycle fetch-done pulse; little-endian word.
REQ-007 lsb_req / lsb_we / lsb_len / lsb_addr / lsb_wdata  input  1/1/2/32/32  data request; len 0=byte, 1=half, 2=word.
REQ-008 lsb_ready / lsb_rdata  output  1/32  one-cycle done pulse; load data zero-extended (sign handling is the LSB's job).
REQ-009 mem_din  input  8  RAM read byte, valid one cycle after its address.
REQ-010 mem_dout / mem_a / mem_wr  output  8/32/1  RAM write byte, byte address, write strobe.
REQ-011 io_buffer_full  input  1  I/O sink cannot accept a byte.
REQ-012 mem_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, IFETCH, LOAD, STORE; byte counter cnt is 3 bits and a latched 32-bit base address is used.
REQ-014 In IDLE, at a rising edge with rdy_in high and no clear, a pending request SHALL be granted: lsb_req&lsb_we -> STORE, lsb_req&!lsb_we -> LOAD, if_req -> IFETCH.
REQ-015 Byte count N SHALL be 4 for IFETCH, and 1/2/4 for lsb_len 0/1/2; lsb_len 3 SHALL be treated as 4.
REQ-016 Reads: mem_a SHALL equal base+k with mem_wr=0 during cycle k+1 after the grant edge (k=0..N-1); byte k SHALL be sampled from mem_din one cycle later into bits [8k+7:8k].
REQ-017 Read done: if_ready/lsb_ready SHALL rise N+1 edges after the grant edge with full data valid in that same cycle; the FSM returns to IDLE at that edge.
REQ-018 Writes: mem_wr=1, mem_a=base+k, mem_dout=wdata[8k+7:8k] in cycle k+1; lsb_ready SHALL pulse N edges after the grant edge.
REQ-019 Addresses with bits [17:16]==2'b11 are I/O: while io_buffer_full is high, a STORE SHALL hold cnt with mem_wr=0 and resume when it drops.
REQ-020 Ready pulses SHALL last exactly one cycle; no request SHALL be sampled in a cycle where a ready output is high (requesters drop req on the edge that ends it).
REQ-021 clear SHALL abort IFETCH and LOAD (return to IDLE with no ready pulse, mem_wr=0) and SHALL NOT affect an in-flight STORE, which completes normally.
REQ-022 clear in IDLE SHALL suppress granting on that edge.
REQ-023 rdy_in low SHALL hold state, cnt and outputs, except mem_wr, which SHALL be forced to 0.
REQ-024 Base+k addition SHALL wrap modulo 2^32.
REQ-025 mem_a SHALL be 0 and mem_wr 0 in IDLE.

Reset
REQ-026 On rst_n_in low, asynchronously: state=IDLE, cnt=0, every output=0, last-grant=IF.
REQ-027 Reset asserted mid-transfer SHALL abandon it with no ready pulse.

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: on simultaneous if_req and lsb_req, grant the requester not granted last (last-grant register updated on every grant).
REQ-029 MEM_ARB_RR_EN undefined: LSB SHALL always win ties; last-grant register absent.

Verification
REQ-030 if_req, addr 0x100, RAM bytes 13,05,00,00 -> mem_a 0x100..0x103, if_ready at edge 5, if_data 0x00000513.
REQ-031 Store word 0xDEADBEEF to 0x200 -> mem_wr 4 cycles, bytes EF,BE,AD,DE; lsb_ready at edge 4.
REQ-032 Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> write delayed 3 cycles, then lsb_ready.
REQ-033 clear 2 cycles into IFETCH -> IDLE next edge, no if_ready; clear during STORE -> store completes.
REQ-034 Both requesting each idle period -> RR_EN: alternate LSB/IF; without: LSB every time, IF starved.
REQ-035 rst_n_in low mid-LOAD (no clock edge) -> outputs 0 immediately, no lsb_ready afterwards.
